// File: rtl/sram_responder.sv
// SRAM chip-side responder: byte-lane writes, wait-stated reads, access counters
// and a sticky flag for cycles that assert WE_N and OE_N together.
module sram_responder #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned READ_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    inout  logic [15:0] SRAM_DQ,
    input  logic [17:0] SRAM_adr,
    input  logic        SRAM_UB_N,
    input  logic        SRAM_LB_N,
    input  logic        SRAM_WE_N,
    input  logic        SRAM_CE_N,
    input  logic        SRAM_OE_N,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic        proto_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_VALID
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

    logic [15:0]       mem [2**ADDR_W];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] la_q, la_d;
    logic [15:0]       data_q, data_d;
    logic [15:0]       rd_count_q, rd_count_d;
    logic [15:0]       wr_count_q, wr_count_d;
    logic              err_q, err_d;
    logic              pwr_q;
    logic [ADDR_W-1:0] pa_q;
    logic [1:0]        pm_q;

    logic [ADDR_W-1:0] addr;
    logic [1:0]        mask;
    logic              wr_pin, rd_pin, bad_pin, drive;

    assign addr    = SRAM_adr[ADDR_W-1:0];
    assign mask    = {~SRAM_UB_N, ~SRAM_LB_N};
    assign wr_pin  = !SRAM_CE_N && !SRAM_WE_N &&  SRAM_OE_N;
    assign rd_pin  = !SRAM_CE_N &&  SRAM_WE_N && !SRAM_OE_N;
    assign bad_pin = !SRAM_CE_N && !SRAM_WE_N && !SRAM_OE_N;

    generate
        if (ADDR_W < 18) begin : g_unused_adr
            logic unused_adr;
            assign unused_adr = ^SRAM_adr[17:ADDR_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_pin) begin
            if (!SRAM_UB_N) mem[addr][15:8] <= SRAM_DQ[15:8];
            if (!SRAM_LB_N) mem[addr][7:0]  <= SRAM_DQ[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            la_q       <= '0;
            data_q     <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
            err_q      <= 1'b0;
            pwr_q      <= 1'b0;
            pa_q       <= '0;
            pm_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            la_q       <= la_d;
            data_q     <= data_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            err_q      <= err_d;
            pwr_q      <= wr_pin;
            pa_q       <= addr;
            pm_q       <= mask;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        la_d       = la_q;
        data_d     = data_q;
        rd_count_d = rd_count_q;
        err_d      = err_q | bad_pin;
        // A write held over several edges with unchanged address and lanes is one access.
        wr_count_d = wr_count_q;
        if (wr_pin && !(pwr_q && pa_q == addr && pm_q == mask))
            wr_count_d = wr_count_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                if (rd_pin) begin
                    state_d = S_WAIT;
                    la_d    = addr;
                    cnt_d   = LAT_M1;
                end
            end
            S_WAIT: begin
                if (!rd_pin) begin
                    state_d = S_IDLE;
                end else if (addr != la_q) begin
                    la_d  = addr;
                    cnt_d = LAT_M1;
                end else if (cnt_q == 4'd0) begin
                    state_d    = S_VALID;
                    data_d     = mem[la_q];
                    rd_count_d = rd_count_q + 16'd1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_VALID: begin
                if (!rd_pin) begin
                    state_d = S_IDLE;
                end else if (addr != la_q) begin
                    state_d = S_WAIT;
                    la_d    = addr;
                    cnt_d   = LAT_M1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Drive follows the live pins so bus release needs no clock edge.
    assign drive = (state_q == S_VALID) && rd_pin;
    assign SRAM_DQ[15:8] = (drive && !SRAM_UB_N) ? data_q[15:8] : {8{1'bz}};
    assign SRAM_DQ[7:0]  = (drive && !SRAM_LB_N) ? data_q[7:0]  : {8{1'bz}};

    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: directed vector table, hand-written corner sequences,
// then randomized traffic against a transaction-level model. Undriven DQ reads as 1s.
module tb_sram_responder;

    localparam int unsigned LAT = 2;

    typedef enum logic [1:0] {OP_NO, OP_WR, OP_RD, OP_BAD} op_t;

    typedef struct {
        op_t         op;
        logic [17:0] a;
        logic [15:0] wd;
        logic        ub;
        logic        lb;
        logic        chk_dq;
        logic [15:0] dq;
        logic [15:0] rd;
        logic [15:0] wr;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    tri1  [15:0] SRAM_DQ;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic [17:0] adr;
    logic        ub_n, lb_n, we_n, ce_n, oe_n;
    logic [15:0] rd_count, wr_count;
    logic        proto_err;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    assign SRAM_DQ = dq_oe ? dq_out : 16'bz;

    sram_responder #(.ADDR_W(16), .READ_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .SRAM_DQ   (SRAM_DQ),
        .SRAM_adr  (adr),
        .SRAM_UB_N (ub_n),
        .SRAM_LB_N (lb_n),
        .SRAM_WE_N (we_n),
        .SRAM_CE_N (ce_n),
        .SRAM_OE_N (oe_n),
        .rd_count  (rd_count),
        .wr_count  (wr_count),
        .proto_err (proto_err)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_cnt(input string name, input logic [15:0] rd, input logic [15:0] wr,
                           input logic err);
        chk({name, " rd_count"}, rd_count, rd);
        chk({name, " wr_count"}, wr_count, wr);
        chk({name, " proto_err"}, {15'd0, proto_err}, {15'd0, err});
    endtask

    task automatic apply(input op_t op, input logic [17:0] a, input logic ub, input logic lb,
                         input logic [15:0] wd);
        adr  = a;
        ub_n = ub;
        lb_n = lb;
        case (op)
            OP_WR:   begin ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; end
            OP_RD:   begin ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; end
            OP_BAD:  begin ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0; end
            default: begin ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; end
        endcase
        dq_out = wd;
        dq_oe  = (op == OP_WR);
    endtask

    function automatic vec_t V(input op_t op, input logic [17:0] a, input logic [15:0] wd,
                               input logic ub, input logic lb, input logic chk_dq,
                               input logic [15:0] dq, input logic [15:0] rd,
                               input logic [15:0] wr, input logic err);
        vec_t v;
        v.op = op; v.a = a; v.wd = wd; v.ub = ub; v.lb = lb;
        v.chk_dq = chk_dq; v.dq = dq; v.rd = rd; v.wr = wr; v.err = err;
        return v;
    endfunction

    // Transaction-level model: read progress is the number of consecutive edges
    // that sampled RD at one address; data appears once that exceeds LAT.
    logic [15:0] m_mem [8];
    int unsigned m_age;
    logic [2:0]  m_ra;
    logic [15:0] m_data, m_rd, m_wr;
    logic        m_err, m_pwr;
    logic [2:0]  m_pa;
    logic [1:0]  m_pm;

    task automatic model_reset();
        m_age = 0; m_ra = '0; m_data = '0; m_rd = '0; m_wr = '0;
        m_err = 1'b0; m_pwr = 1'b0; m_pa = '0; m_pm = '0;
    endtask

    function automatic logic [15:0] model_dq(input op_t op, input logic ub, input logic lb,
                                             input logic [15:0] wd);
        logic [15:0] e;
        e = 16'hFFFF;
        if (op == OP_WR) e = wd;
        else if (op == OP_RD && m_age > LAT) begin
            if (!ub) e[15:8] = m_data[15:8];
            if (!lb) e[7:0]  = m_data[7:0];
        end
        return e;
    endfunction

    task automatic model_edge(input op_t op, input logic [17:0] a, input logic ub,
                              input logic lb, input logic [15:0] wd);
        logic [2:0] ai;
        logic [1:0] m;
        ai = a[2:0];
        m  = {~ub, ~lb};
        if (op == OP_WR) begin
            if (!ub) m_mem[ai][15:8] = wd[15:8];
            if (!lb) m_mem[ai][7:0]  = wd[7:0];
            if (!(m_pwr && m_pa == ai && m_pm == m)) m_wr = m_wr + 16'd1;
        end
        m_pwr = (op == OP_WR);
        m_pa  = ai;
        m_pm  = m;
        if (op == OP_BAD) m_err = 1'b1;
        if (op != OP_RD) m_age = 0;
        else if (m_age == 0 || ai != m_ra) begin
            m_ra  = ai;
            m_age = 1;
        end else if (m_age <= LAT) begin
            m_age++;
            if (m_age == LAT + 1) begin
                m_data = m_mem[m_ra];
                m_rd   = m_rd + 16'd1;
            end
        end
    endtask

    task automatic rcycle(input op_t op, input logic [17:0] a, input logic ub, input logic lb,
                          input logic [15:0] wd);
        @(negedge clk);
        apply(op, a, ub, lb, wd);
        #1;
        chk("rand dq", SRAM_DQ, model_dq(op, ub, lb, wd));
        @(posedge clk);
        model_edge(op, a, ub, lb, wd);
        #1;
        chk_cnt("rand", m_rd, m_wr, m_err);
    endtask

    vec_t tbl[$];

    initial begin
        op_t         op;
        logic [17:0] ra;
        logic        rub, rlb;
        logic [15:0] rwd;

        // Directed write/read/byte-lane/protocol-error vectors, applied from reset.
        tbl.push_back(V(OP_WR,  18'h00123, 16'hBEEF, 0, 0, 0, 16'h0000, 0, 1, 0));
        tbl.push_back(V(OP_WR,  18'h00123, 16'hBEEF, 0, 0, 0, 16'h0000, 0, 1, 0));
        tbl.push_back(V(OP_WR,  18'h00123, 16'hBEEF, 0, 0, 0, 16'h0000, 0, 1, 0));
        tbl.push_back(V(OP_NO,  18'h00000, 16'h0000, 0, 0, 1, 16'hFFFF, 0, 1, 0));
        tbl.push_back(V(OP_RD,  18'h00123, 16'h0000, 0, 0, 1, 16'hFFFF, 0, 1, 0));
        tbl.push_back(V(OP_RD,  18'h00123, 16'h0000, 0, 0, 1, 16'hFFFF, 0, 1, 0));
        tbl.push_back(V(OP_RD,  18'h00123, 16'h0000, 0, 0, 1, 16'hBEEF, 1, 1, 0));
        tbl.push_back(V(OP_RD,  18'h00123, 16'h0000, 0, 0, 1, 16'hBEEF, 1, 1, 0));
        tbl.push_back(V(OP_WR,  18'h00123, 16'h1234, 0, 1, 0, 16'h0000, 1, 2, 0));
        tbl.push_back(V(OP_RD,  18'h00123, 16'h0000, 0, 0, 1, 16'hFFFF, 1, 2, 0));
        tbl.push_back(V(OP_RD,  18'h00123, 16'h0000, 0, 0, 1, 16'hFFFF, 1, 2, 0));
        tbl.push_back(V(OP_RD,  18'h00123, 16'h0000, 0, 0, 1, 16'h12EF, 2, 2, 0));
        tbl.push_back(V(OP_RD,  18'h00123, 16'h0000, 1, 0, 1, 16'hFFEF, 2, 2, 0));
        tbl.push_back(V(OP_BAD, 18'h00123, 16'h0000, 0, 0, 1, 16'hFFFF, 2, 2, 1));
        tbl.push_back(V(OP_RD,  18'h00123, 16'h0000, 0, 0, 1, 16'hFFFF, 2, 2, 1));
        tbl.push_back(V(OP_RD,  18'h00123, 16'h0000, 0, 0, 1, 16'hFFFF, 2, 2, 1));
        tbl.push_back(V(OP_RD,  18'h00123, 16'h0000, 0, 0, 1, 16'h12EF, 3, 2, 1));
        tbl.push_back(V(OP_WR,  18'h00123, 16'hBEEF, 0, 0, 0, 16'h0000, 3, 3, 1));
        tbl.push_back(V(OP_WR,  18'h00124, 16'hBEEF, 0, 0, 0, 16'h0000, 3, 4, 1));
        tbl.push_back(V(OP_WR,  18'h00124, 16'h1234, 0, 1, 0, 16'h0000, 3, 5, 1));
        tbl.push_back(V(OP_NO,  18'h00124, 16'h0000, 0, 0, 1, 16'hFFFF, 3, 5, 1));
        tbl.push_back(V(OP_WR,  18'h00124, 16'h1234, 0, 1, 0, 16'h0000, 3, 6, 1));
        tbl.push_back(V(OP_RD,  18'h10124, 16'h0000, 0, 0, 1, 16'hFFFF, 3, 6, 1));
        tbl.push_back(V(OP_RD,  18'h10124, 16'h0000, 0, 0, 1, 16'hFFFF, 3, 6, 1));
        tbl.push_back(V(OP_RD,  18'h10124, 16'h0000, 0, 0, 1, 16'h12EF, 4, 6, 1));

        rst = 1'b1;
        apply(OP_NO, '0, 1'b1, 1'b1, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset dq", SRAM_DQ, 16'hFFFF);
        chk_cnt("reset", 0, 0, 1'b0);
        @(negedge clk) rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i].op, tbl[i].a, tbl[i].ub, tbl[i].lb, tbl[i].wd);
            @(posedge clk);
            #1;
            if (tbl[i].chk_dq) chk($sformatf("vec%0d dq", i), SRAM_DQ, tbl[i].dq);
            chk_cnt($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].err);
        end

        // Reset mid-read: immediate release, then a full wait with RD held.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst async dq", SRAM_DQ, 16'hFFFF);
        chk_cnt("rst async", 0, 0, 1'b0);
        @(posedge clk);
        #1;
        chk("rst held dq", SRAM_DQ, 16'hFFFF);
        @(negedge clk) rst = 1'b0;
        for (int unsigned e = 0; e <= LAT; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst E%0d dq", e), SRAM_DQ, (e == LAT) ? 16'h12EF : 16'hFFFF);
        end
        chk_cnt("rst reread", 1, 0, 1'b0);

        // Address change while waiting restarts the full wait at the new address.
        @(negedge clk) apply(OP_WR, 18'h5, 1'b0, 1'b0, 16'hA5A5);
        @(negedge clk) apply(OP_WR, 18'h6, 1'b0, 1'b0, 16'h6C6C);
        @(negedge clk) apply(OP_RD, 18'h5, 1'b0, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        chk("achg E0 dq", SRAM_DQ, 16'hFFFF);
        @(negedge clk) adr = 18'h6;
        for (int unsigned e = 1; e <= LAT + 1; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("achg E%0d dq", e), SRAM_DQ, (e == LAT + 1) ? 16'h6C6C : 16'hFFFF);
        end
        chk_cnt("achg", 2, 2, 1'b0);

        // Same-cycle release on CE_N, WE_N and OE_N while data is valid.
        @(negedge clk);
        ce_n = 1'b1; #1; chk("rel ce dq", SRAM_DQ, 16'hFFFF);
        ce_n = 1'b0; #1; chk("rel ce back dq", SRAM_DQ, 16'h6C6C);
        we_n = 1'b0; #1; chk("rel we dq", SRAM_DQ, 16'hFFFF);
        we_n = 1'b1; #1; chk("rel we back dq", SRAM_DQ, 16'h6C6C);
        oe_n = 1'b1; #1; chk("rel oe dq", SRAM_DQ, 16'hFFFF);
        @(posedge clk);
        #1;
        oe_n = 1'b0;
        #1;
        chk("rel idle dq", SRAM_DQ, 16'hFFFF);
        for (int unsigned e = 0; e <= LAT; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rel E%0d dq", e), SRAM_DQ, (e == LAT) ? 16'h6C6C : 16'hFFFF);
        end
        chk_cnt("rel", 3, 2, 1'b0);

        // Randomized traffic over eight addresses (upper address bits scrambled).
        @(negedge clk);
        apply(OP_NO, '0, 1'b1, 1'b1, '0);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        model_reset();
        for (int unsigned i = 0; i < 8; i++)
            rcycle(OP_WR, 18'(i), 1'b0, 1'b0, 16'($urandom));
        op = OP_NO; ra = '0; rub = 1'b0; rlb = 1'b0; rwd = '0;
        for (int unsigned i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(19))
                    0, 1, 2, 3, 4, 5, 6, 7, 8, 9: op = OP_RD;
                    10, 11, 12, 13, 14:           op = OP_WR;
                    15, 16, 17:                   op = OP_NO;
                    default:                      op = OP_BAD;
                endcase
                ra  = {2'($urandom), 13'd0, 3'($urandom)};
                rub = ($urandom_range(3) == 0);
                rlb = ($urandom_range(3) == 0);
                rwd = 16'($urandom);
            end else if ($urandom_range(7) == 0) begin
                ra = {2'($urandom), 13'd0, 3'($urandom)};
            end
            rcycle(op, ra, rub, rlb, rwd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
# sram_responder

Synthesizable responder for the external 16-bit asynchronous-style SRAM interface driven by the pipeline's MEM stage. It plays the SRAM chip side of the pins, with a clocked internal array and a programmable read wait-state counter. It also counts accesses and flags protocol violations, so the MEM-stage SRAM controller can be run and checked on the FPGA or in simulation without the physical chip.

## Interface
- ADDR_W, 16: SRAM_adr bits decoded; array depth is 2^ADDR_W halfwords; upper address bits are ignored.
- READ_LAT, 2: read wait states, legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- SRAM_DQ  inout  16  data bus; driven only as specified below, otherwise Z.
- SRAM_adr  input  18  halfword address.
- SRAM_UB_N  input  1  upper byte lane [15:8] enable, active-low.
- SRAM_LB_N  input  1  lower byte lane [7:0] enable, active-low.
- SRAM_WE_N  input  1  write enable, active-low.
- SRAM_CE_N  input  1  chip enable, active-low.
- SRAM_OE_N  input  1  output enable, active-low.
- rd_count  output  16  completed reads, wraps at 2^16.
- wr_count  output  16  distinct write accesses, wraps at 2^16.
- proto_err  output  1  sticky protocol-violation flag.

## Operation
- Conditions are evaluated on the pins at each rising clk.
  - WR: CE_N=0, WE_N=0, OE_N=1.
  - RD: CE_N=0, OE_N=0, WE_N=1.
  - BAD: CE_N=0, WE_N=0, OE_N=0.
- A = SRAM_adr[ADDR_W-1:0].
- Write: on each edge sampling WR, mem[A][15:8] is written if UB_N=0 and mem[A][7:0] is written if LB_N=0.
  - wr_count increments when the previous edge did not sample WR with the same A and byte mask. A multi-cycle write counts once.
- Read FSM has three states: IDLE, WAIT, VALID. It keeps a latched address LA and a 4-bit counter cnt.
  - IDLE: RD → WAIT, LA←A, cnt←READ_LAT-1.
  - WAIT: if not RD → IDLE. If RD and A≠LA → restart (LA←A, cnt←READ_LAT-1). If RD and cnt=0 → VALID, data_q←mem[LA], rd_count+1. Otherwise cnt−1.
  - VALID: if not RD → IDLE. If RD and A≠LA → WAIT (restart as above). Otherwise hold.
- DQ drive (combinational): drive only when state=VALID and RD is true on the current pins.
  - [15:8]=data_q[15:8] if UB_N=0, else Z.
  - [7:0]=data_q[7:0] if LB_N=0, else Z.
  - Raising OE_N or CE_N, or lowering WE_N, releases DQ in the same cycle, without waiting for a clock edge.
- BAD: no write, no read progress (the FSM treats it as not RD and goes to IDLE), DQ stays Z, and proto_err←1 at that edge.
- CE_N=1: no access. The FSM returns to IDLE.

## Timing
- Reset values:
  - FSM=IDLE, cnt=0, LA=0, data_q=0.
  - rd_count=0, wr_count=0, proto_err=0.
  - DQ=Z.
  - mem is not reset; its contents are undefined until written.
- Read latency: RD first sampled at edge E0 → valid DQ from just after edge E(READ_LAT) while RD holds. READ_LAT=1 means data is on DQ the cycle after the first sampled RD cycle.
- An address change restarts the full READ_LAT wait, measured from the edge that sampled the new A.
- A write takes effect at the sampling edge. A read entering VALID at a later edge returns the new data.
- proto_err clears only on rst.
- Counters wrap silently at 0xFFFF→0x0000.
- rst asserted mid-read: FSM goes to IDLE and DQ goes to Z immediately (asynchronously). After release, a new read needs a full READ_LAT.
- READ_LAT outside 1..15 is illegal configuration; behaviour is unspecified.

## Test plan
- Reset: assert rst with RD pins active → DQ=Z, rd_count=0, wr_count=0, proto_err=0. After release with RD held and READ_LAT=2, DQ is driven only after the 2nd edge.
- Write/read: write 0xBEEF to A=0x0123 (UB_N=LB_N=0) for 3 cycles → wr_count=1. Then RD at 0x0123 with READ_LAT=2 → DQ=0xBEEF from edge E2, rd_count=1.
- Byte lanes: write 0x12 to the upper lane only (LB_N=1) at A=0x0123 over 0xBEEF → read with both lanes = 0x12EF. Read with UB_N=1 → DQ[15:8]=Z, DQ[7:0]=0xEF.
- Address change mid-WAIT: start RD at A=5, change to A=6 at E1 → DQ=mem[6] valid from E3 (READ_LAT=2). mem[5] is never driven; rd_count increments once.
- Release: in VALID, raise OE_N between edges → DQ=Z in the same cycle, FSM=IDLE at the next edge.
- Protocol error: CE_N=WE_N=OE_N=0 for one edge → proto_err=1, mem unchanged, DQ=Z. proto_err stays 1 through later legal traffic until rst.
